// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - RV32I decode-to-execute pipeline register (optional feature macro: IDEX_PERF_CNT_EN)
module id_ex_pipe_reg #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic            reg_write_d,
    input  logic [1:0]      result_src_d,
    input  logic            mem_write_d,
    input  logic            jump_d,
    input  logic            branch_d,
    input  logic [3:0]      alu_control_d,
    input  logic            alu_src_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic [XLEN-1:0] imm_ext_d,
    input  logic [REGW-1:0] rs1_d,
    input  logic [REGW-1:0] rs2_d,
    input  logic [REGW-1:0] rd_d,
    output logic            valid_e,
    output logic            reg_write_e,
    output logic [1:0]      result_src_e,
    output logic            mem_write_e,
    output logic            jump_e,
    output logic            branch_e,
    output logic [3:0]      alu_control_e,
    output logic            alu_src_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [REGW-1:0] rs1_e,
    output logic [REGW-1:0] rs2_e,
    output logic [REGW-1:0] rd_e,
    output logic [31:0]     bubble_cnt,
    output logic [31:0]     stall_cnt
);

    // Registered execute-stage state
    logic            valid_e_q;
    logic            reg_write_e_q;
    logic [1:0]      result_src_e_q;
    logic            mem_write_e_q;
    logic            jump_e_q;
    logic            branch_e_q;
    logic [3:0]      alu_control_e_q;
    logic            alu_src_e_q;
    logic [XLEN-1:0] rd1_e_q;
    logic [XLEN-1:0] rd2_e_q;
    logic [XLEN-1:0] pc_e_q;
    logic [XLEN-1:0] pc_plus4_e_q;
    logic [XLEN-1:0] imm_ext_e_q;
    logic [REGW-1:0] rs1_e_q;
    logic [REGW-1:0] rs2_e_q;
    logic [REGW-1:0] rd_e_q;

    // Next-state values
    logic            valid_e_d;
    logic            reg_write_e_d;
    logic [1:0]      result_src_e_d;
    logic            mem_write_e_d;
    logic            jump_e_d;
    logic            branch_e_d;
    logic [3:0]      alu_control_e_d;
    logic            alu_src_e_d;
    logic [XLEN-1:0] rd1_e_d;
    logic [XLEN-1:0] rd2_e_d;
    logic [XLEN-1:0] pc_e_d;
    logic [XLEN-1:0] pc_plus4_e_d;
    logic [XLEN-1:0] imm_ext_e_d;
    logic [REGW-1:0] rs1_e_d;
    logic [REGW-1:0] rs2_e_d;
    logic [REGW-1:0] rd_e_d;

    // Next-state select: flush beats stall beats capture; an invalid slot never carries side effects
    always_comb begin
        valid_e_d       = valid_e_q;
        reg_write_e_d   = reg_write_e_q;
        result_src_e_d  = result_src_e_q;
        mem_write_e_d   = mem_write_e_q;
        jump_e_d        = jump_e_q;
        branch_e_d      = branch_e_q;
        alu_control_e_d = alu_control_e_q;
        alu_src_e_d     = alu_src_e_q;
        rd1_e_d         = rd1_e_q;
        rd2_e_d         = rd2_e_q;
        pc_e_d          = pc_e_q;
        pc_plus4_e_d    = pc_plus4_e_q;
        imm_ext_e_d     = imm_ext_e_q;
        rs1_e_d         = rs1_e_q;
        rs2_e_d         = rs2_e_q;
        rd_e_d          = rd_e_q;
        if (flush_e) begin
            // Bubble: all-zero bundle, zero register indices so forwarding never matches
            valid_e_d       = 1'b0;
            reg_write_e_d   = 1'b0;
            result_src_e_d  = 2'b00;
            mem_write_e_d   = 1'b0;
            jump_e_d        = 1'b0;
            branch_e_d      = 1'b0;
            alu_control_e_d = 4'b0000;
            alu_src_e_d     = 1'b0;
            rd1_e_d         = '0;
            rd2_e_d         = '0;
            pc_e_d          = '0;
            pc_plus4_e_d    = '0;
            imm_ext_e_d     = '0;
            rs1_e_d         = '0;
            rs2_e_d         = '0;
            rd_e_d          = '0;
        end else if (!stall_e) begin
            valid_e_d       = valid_d;
            reg_write_e_d   = reg_write_d & valid_d;
            result_src_e_d  = result_src_d;
            mem_write_e_d   = mem_write_d & valid_d;
            jump_e_d        = jump_d & valid_d;
            branch_e_d      = branch_d & valid_d;
            alu_control_e_d = alu_control_d;
            alu_src_e_d     = alu_src_d;
            rd1_e_d         = rd1_d;
            rd2_e_d         = rd2_d;
            pc_e_d          = pc_d;
            pc_plus4_e_d    = pc_plus4_d;
            imm_ext_e_d     = imm_ext_d;
            rs1_e_d         = rs1_d;
            rs2_e_d         = rs2_d;
            rd_e_d          = rd_d;
        end
    end

    // Pipeline register bank with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e_q       <= 1'b0;
            reg_write_e_q   <= 1'b0;
            result_src_e_q  <= 2'b00;
            mem_write_e_q   <= 1'b0;
            jump_e_q        <= 1'b0;
            branch_e_q      <= 1'b0;
            alu_control_e_q <= 4'b0000;
            alu_src_e_q     <= 1'b0;
            rd1_e_q         <= '0;
            rd2_e_q         <= '0;
            pc_e_q          <= '0;
            pc_plus4_e_q    <= '0;
            imm_ext_e_q     <= '0;
            rs1_e_q         <= '0;
            rs2_e_q         <= '0;
            rd_e_q          <= '0;
        end else begin
            valid_e_q       <= valid_e_d;
            reg_write_e_q   <= reg_write_e_d;
            result_src_e_q  <= result_src_e_d;
            mem_write_e_q   <= mem_write_e_d;
            jump_e_q        <= jump_e_d;
            branch_e_q      <= branch_e_d;
            alu_control_e_q <= alu_control_e_d;
            alu_src_e_q     <= alu_src_e_d;
            rd1_e_q         <= rd1_e_d;
            rd2_e_q         <= rd2_e_d;
            pc_e_q          <= pc_e_d;
            pc_plus4_e_q    <= pc_plus4_e_d;
            imm_ext_e_q     <= imm_ext_e_d;
            rs1_e_q         <= rs1_e_d;
            rs2_e_q         <= rs2_e_d;
            rd_e_q          <= rd_e_d;
        end
    end

    assign valid_e       = valid_e_q;
    assign reg_write_e   = reg_write_e_q;
    assign result_src_e  = result_src_e_q;
    assign mem_write_e   = mem_write_e_q;
    assign jump_e        = jump_e_q;
    assign branch_e      = branch_e_q;
    assign alu_control_e = alu_control_e_q;
    assign alu_src_e     = alu_src_e_q;
    assign rd1_e         = rd1_e_q;
    assign rd2_e         = rd2_e_q;
    assign pc_e          = pc_e_q;
    assign pc_plus4_e    = pc_plus4_e_q;
    assign imm_ext_e     = imm_ext_e_q;
    assign rs1_e         = rs1_e_q;
    assign rs2_e         = rs2_e_q;
    assign rd_e          = rd_e_q;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_d;
    logic [31:0] stall_cnt_d;

    // Saturating counters: a flushed edge is a bubble even if stall is also asserted
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (flush_e) begin
            if (bubble_cnt_q != 32'hFFFF_FFFF) begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
        end else if (stall_e) begin
            if (stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`else
    assign bubble_cnt = 32'd0;
    assign stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

    localparam int BW = 1 + 1 + 2 + 1 + 1 + 1 + 4 + 1 + 5 * 32 + 3 * 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_e = 1'b0, flush_e = 1'b0, valid_d = 1'b0;
    logic        reg_write_d = 1'b0, mem_write_d = 1'b0, jump_d = 1'b0, branch_d = 1'b0, alu_src_d = 1'b0;
    logic [1:0]  result_src_d = '0;
    logic [3:0]  alu_control_d = '0;
    logic [31:0] rd1_d = '0, rd2_d = '0, pc_d = '0, pc_plus4_d = '0, imm_ext_d = '0;
    logic [4:0]  rs1_d = '0, rs2_d = '0, rd_d = '0;

    logic        valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
    logic [1:0]  result_src_e;
    logic [3:0]  alu_control_e;
    logic [31:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [31:0] bubble_cnt, stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [BW-1:0] exp_b;
    longint        exp_bub;
    longint        exp_stl;
    logic [BW-1:0] snap;

    id_ex_pipe_reg #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .reg_write_d(reg_write_d), .result_src_d(result_src_d), .mem_write_d(mem_write_d),
        .jump_d(jump_d), .branch_d(branch_d), .alu_control_d(alu_control_d), .alu_src_d(alu_src_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .imm_ext_d(imm_ext_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
        .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
        .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .imm_ext_e(imm_ext_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] pack(
        input logic v, input logic rw, input logic [1:0] rs, input logic mw, input logic j,
        input logic b, input logic [3:0] alu, input logic as,
        input logic [31:0] a, input logic [31:0] bb, input logic [31:0] pc,
        input logic [31:0] pc4, input logic [31:0] imm,
        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        return {v, rw, rs, mw, j, b, alu, as, a, bb, pc, pc4, imm, s1, s2, d};
    endfunction

    function automatic logic [BW-1:0] observed();
        return pack(valid_e, reg_write_e, result_src_e, mem_write_e, jump_e, branch_e,
                    alu_control_e, alu_src_e, rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e,
                    rs1_e, rs2_e, rd_e);
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_cnt(input string tag);
        logic [31:0] eb;
        logic [31:0] es;
`ifdef IDEX_PERF_CNT_EN
        eb = 32'(exp_bub);
        es = 32'(exp_stl);
`else
        eb = 32'd0;
        es = 32'd0;
`endif
        n_cmp++;
        assert (bubble_cnt === eb) else begin
            n_bad++;
            $error("FAIL %s_bubble observed=%h expected=%h", tag, bubble_cnt, eb);
        end
        n_cmp++;
        assert (stall_cnt === es) else begin
            n_bad++;
            $error("FAIL %s_stall observed=%h expected=%h", tag, stall_cnt, es);
        end
    endtask

    task automatic randomize_inputs();
        valid_d       = 1'($urandom);
        reg_write_d   = 1'($urandom);
        result_src_d  = 2'($urandom);
        mem_write_d   = 1'($urandom);
        jump_d        = 1'($urandom);
        branch_d      = 1'($urandom);
        alu_control_d = 4'($urandom);
        alu_src_d     = 1'($urandom);
        rd1_d         = $urandom;
        rd2_d         = $urandom;
        pc_d          = $urandom;
        pc_plus4_d    = $urandom;
        imm_ext_d     = $urandom;
        rs1_d         = 5'($urandom);
        rs2_d         = 5'($urandom);
        rd_d          = 5'($urandom);
    endtask

    // One clock edge: update the reference model from the inputs seen at the edge, then compare
    task automatic step(input string tag);
        @(posedge clk);
        if (flush_e) begin
            exp_b   = '0;
            exp_bub = (exp_bub < 64'hFFFF_FFFF) ? exp_bub + 1 : exp_bub;
        end else if (stall_e) begin
            exp_stl = (exp_stl < 64'hFFFF_FFFF) ? exp_stl + 1 : exp_stl;
        end else begin
            exp_b = pack(valid_d, reg_write_d && valid_d, result_src_d, mem_write_d && valid_d,
                         jump_d && valid_d, branch_d && valid_d, alu_control_d, alu_src_d,
                         rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d, rs1_d, rs2_d, rd_d);
        end
        #1;
        chk(tag, observed(), exp_b);
    endtask

    initial begin
        exp_b   = '0;
        exp_bub = 0;
        exp_stl = 0;

        // Reset state
        #2;
        chk("reset_state", observed(), '0);
        chk_cnt("reset_cnt");
        @(negedge clk);
        rst_n = 1'b1;

        // Normal capture
        valid_d = 1'b1; reg_write_d = 1'b1; result_src_d = 2'b01; alu_control_d = 4'b0010;
        rd_d = 5'd7; rd1_d = 32'h0000_1234;
        step("capture");
        chk("capture_fields", {valid_e, reg_write_e, result_src_e, alu_control_e, rd_e, rd1_e},
            {1'b1, 1'b1, 2'b01, 4'b0010, 5'd7, 32'h0000_1234});

        // Stall three cycles with changing inputs
        snap = exp_b;
        stall_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            step("stall_hold");
            chk("stall_unchanged", observed(), snap);
        end
        chk_cnt("stall3");
        stall_e = 1'b0;

        // Flush and stall together
        randomize_inputs();
        valid_d = 1'b1; reg_write_d = 1'b1; mem_write_d = 1'b1; rd_d = 5'd9;
        flush_e = 1'b1; stall_e = 1'b1;
        step("flush_stall");
        chk("flush_ctrl", {valid_e, reg_write_e, mem_write_e, rd_e}, '0);
        chk_cnt("flush_stall_cnt");
        flush_e = 1'b0; stall_e = 1'b0;

        // Invalid decode slot
        randomize_inputs();
        valid_d = 1'b0; jump_d = 1'b1; branch_d = 1'b1; mem_write_d = 1'b1;
        step("invalid_slot");
        chk("invalid_ctrl", {jump_e, branch_e, mem_write_e, valid_e}, '0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            stall_e = ($urandom_range(0, 3) == 0);
            flush_e = ($urandom_range(0, 4) == 0);
            step("random");
            if (i % 50 == 49) chk_cnt("random_cnt");
        end
        flush_e = 1'b0; stall_e = 1'b0;

        // Asynchronous reset mid-cycle, with nonzero inputs and held outputs
        randomize_inputs();
        valid_d = 1'b1; reg_write_d = 1'b1; rd1_d = 32'hDEAD_BEEF;
        step("pre_reset");
        stall_e = 1'b1; flush_e = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_b = '0; exp_bub = 0; exp_stl = 0;
        chk("async_reset", observed(), '0);
        chk_cnt("async_reset_cnt");
        @(negedge clk);
        rst_n = 1'b1;
        stall_e = 1'b0; flush_e = 1'b0;
        randomize_inputs();
        step("post_reset");

`ifdef IDEX_PERF_CNT_EN
        // Saturation of the bubble counter
        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt_q;
        exp_bub = 64'hFFFF_FFFE;
        flush_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            step("sat_flush");
            chk_cnt("bubble_sat");
        end
        flush_e = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
